// File: rtl/mod_det_loader_pkg.sv
// Shared definitions for the determinant loader: FSM states, element counts
// and the register-bank slot numbering (row-major a..i = 0..8).
package mod_det_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  localparam int N3    = 9;
  localparam int N2    = 4;
  localparam int NSLOT = 9;

  // Slots that receive the four 2x2 elements (lower-right minor of the 3x3).
  localparam int SLOT_E = 4;
  localparam int SLOT_F = 5;
  localparam int SLOT_H = 7;
  localparam int SLOT_I = 8;

endpackage

// File: rtl/det_slot_map.sv
// Maps the running element index to a one-hot register-bank write enable.
// 3x3 mode fills a..i in order; 2x2 mode fills only e,f,h,i.
module det_slot_map
  import mod_det_loader_pkg::*;
(
  input  logic [3:0]       idx,
  input  logic             size3,
  output logic [NSLOT-1:0] we
);

  // Decode index to the slot it writes; out-of-range indices write nothing.
  always_comb begin
    we = '0;
    if (size3) begin
      for (int k = 0; k < NSLOT; k++) begin
        if (idx == 4'(k)) we[k] = 1'b1;
      end
    end else begin
      case (idx)
        4'd0:    we[SLOT_E] = 1'b1;
        4'd1:    we[SLOT_F] = 1'b1;
        4'd2:    we[SLOT_H] = 1'b1;
        4'd3:    we[SLOT_I] = 1'b1;
        default: we = '0;
      endcase
    end
  end

endmodule

// File: rtl/mod_det_loader.sv
// Serial feeder and result capture for a combinational 3x3 determinant unit.
// Elements stream in row-major, are held in a 3x3 bank, the det path is given
// SETTLE_CYCLES to resolve, then its output is registered and done pulses.
module mod_det_loader
  import mod_det_loader_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     size3,
  input  logic signed [DATA_W-1:0] elem_in,
  input  logic                     elem_valid,
  output logic                     elem_ready,
  output logic signed [DATA_W-1:0] m_a,
  output logic signed [DATA_W-1:0] m_b,
  output logic signed [DATA_W-1:0] m_c,
  output logic signed [DATA_W-1:0] m_d,
  output logic signed [DATA_W-1:0] m_e,
  output logic signed [DATA_W-1:0] m_f,
  output logic signed [DATA_W-1:0] m_g,
  output logic signed [DATA_W-1:0] m_h,
  output logic signed [DATA_W-1:0] m_i,
  input  logic signed [DATA_W-1:0] det_in,
  output logic signed [DATA_W-1:0] result,
  output logic                     busy,
  output logic                     done
);

  localparam int              CW       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_INIT = CW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]      LAST3    = 4'(N3 - 1);
  localparam logic [3:0]      LAST2    = 4'(N2 - 1);

  state_t                    state_q, state_d;
  logic [3:0]                idx_q;
  logic [CW-1:0]             cnt_q;
  logic                      size3_q;
  logic                      load_start, xfer, capture, last_idx;
  logic [NSLOT-1:0]          we;
  logic signed [DATA_W-1:0]  m_q [NSLOT];

  assign last_idx = (idx_q == (size3_q ? LAST3 : LAST2));

  det_slot_map u_slot_map (
    .idx   (idx_q),
    .size3 (size3_q),
    .we    (we)
  );

  // Next-state and handshake decode.
  always_comb begin
    state_d    = state_q;
    elem_ready = 1'b0;
    busy       = 1'b0;
    load_start = 1'b0;
    xfer       = 1'b0;
    capture    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_start = 1'b1;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        elem_ready = 1'b1;
        busy       = 1'b1;
        xfer       = elem_valid;
        if (elem_valid && last_idx) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        busy = 1'b1;
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Element index, mode latch and settle countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      cnt_q   <= '0;
      size3_q <= 1'b0;
    end else begin
      if (load_start) begin
        size3_q <= size3;
        idx_q   <= '0;
      end else if (xfer) begin
        idx_q <= idx_q + 4'd1;
      end
      if (xfer && last_idx)                         cnt_q <= CNT_INIT;
      else if (state_q == ST_SETTLE && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Register bank preset/fill, result capture and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSLOT; k++) m_q[k] <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= capture;
      if (capture) result <= det_in;
      if (load_start) begin
        // 2x2 embeds as [[1,0,0],[0,e,f],[0,h,i]] so the 3x3 det is e*i-f*h.
        for (int k = 0; k < NSLOT; k++) m_q[k] <= '0;
        if (!size3) m_q[0] <= DATA_W'(1);
      end else if (xfer) begin
        for (int k = 0; k < NSLOT; k++) begin
          if (we[k]) m_q[k] <= elem_in;
        end
      end
    end
  end

  assign m_a = m_q[0];
  assign m_b = m_q[1];
  assign m_c = m_q[2];
  assign m_d = m_q[3];
  assign m_e = m_q[4];
  assign m_f = m_q[5];
  assign m_g = m_q[6];
  assign m_h = m_q[7];
  assign m_i = m_q[8];

endmodule

// File: tb/tb_mod_det_loader.sv
// Bench for mod_det_loader with a behavioural 3x3 determinant unit attached.
module tb_mod_det_loader;

  localparam int DATA_W = 8;
  localparam int SC     = 2;

  logic clk = 1'b0;
  logic rst, start, size3, elem_valid;
  logic signed [DATA_W-1:0] elem_in, det_in, result;
  logic signed [DATA_W-1:0] m_a, m_b, m_c, m_d, m_e, m_f, m_g, m_h, m_i;
  logic elem_ready, busy, done;

  typedef struct {
    logic [DATA_W-1:0] res;
    int                xcyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mod_det_loader #(.DATA_W(DATA_W), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .start(start), .size3(size3),
    .elem_in(elem_in), .elem_valid(elem_valid), .elem_ready(elem_ready),
    .m_a(m_a), .m_b(m_b), .m_c(m_c), .m_d(m_d), .m_e(m_e),
    .m_f(m_f), .m_g(m_g), .m_h(m_h), .m_i(m_i),
    .det_in(det_in), .result(result), .busy(busy), .done(done)
  );

  // Stand-in for the combinational det unit: cofactor expansion on row 0.
  function automatic logic signed [DATA_W-1:0] det_unit(
    input int a, input int b, input int c, input int d, input int e,
    input int f, input int g, input int h, input int i);
    return DATA_W'(a * (e * i - f * h) - b * (d * i - f * g) + c * (d * h - e * g));
  endfunction

  assign det_in = det_unit(m_a, m_b, m_c, m_d, m_e, m_f, m_g, m_h, m_i);

  function automatic int sx(input int x);
    logic signed [DATA_W-1:0] t;
    t = DATA_W'(x);
    return int'(t);
  endfunction

  // Reference: rule of Sarrus for 3x3, ad-bc for 2x2, reduced mod 2^DATA_W.
  function automatic logic [DATA_W-1:0] ref_det(input bit s3, input int v[9]);
    int w[9];
    int r;
    for (int k = 0; k < 9; k++) w[k] = sx(v[k]);
    if (s3)
      r = w[0]*w[4]*w[8] + w[1]*w[5]*w[6] + w[2]*w[3]*w[7]
        - w[2]*w[4]*w[6] - w[1]*w[3]*w[8] - w[0]*w[5]*w[7];
    else
      r = w[0]*w[3] - w[1]*w[2];
    return DATA_W'(r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Monitor: every done pulse must match the oldest outstanding matrix.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        timeout_fail("unexpected_done");
      end else begin
        mon_e = exp_q.pop_front();
        check("result", {24'b0, result}, {24'b0, mon_e.res});
        check("latency", cyc + 1 - mon_e.xcyc, 1 + SC);
        check("busy_at_done", {31'b0, busy}, 32'd0);
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (busy) timeout_fail("wait_idle");
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!done) timeout_fail("wait_done");
  endtask

  // gaps: 0 back-to-back, 1 valid every other cycle, 2 random gaps.
  // noise: start pulses in LOAD gaps, start and elem_valid during SETTLE.
  task automatic load_matrix(input bit s3, input int v[9], input int gaps, input bit noise);
    int   n;
    int   g;
    exp_t e;
    n = s3 ? 9 : 4;
    wait_idle();
    start = 1'b1;
    size3 = s3;
    @(posedge clk); #1;
    start = 1'b0;
    size3 = $urandom_range(0, 1);
    check("ready_in_load", {31'b0, elem_ready}, 32'd1);
    for (int k = 0; k < n; k++) begin
      g = (gaps == 1) ? 1 : ((gaps == 2) ? $urandom_range(0, 3) : 0);
      repeat (g) begin
        elem_valid = 1'b0;
        elem_in    = DATA_W'($urandom);
        start      = noise;
        @(posedge clk); #1;
        check("ready_gap", {31'b0, elem_ready}, 32'd1);
      end
      start      = 1'b0;
      elem_valid = 1'b1;
      elem_in    = DATA_W'(v[k]);
      @(posedge clk); #1;
    end
    elem_valid = 1'b0;
    e.xcyc = cyc;
    e.res  = ref_det(s3, v);
    exp_q.push_back(e);
    check("ready_in_settle", {31'b0, elem_ready}, 32'd0);
    check("busy_in_settle", {31'b0, busy}, 32'd1);
    if (noise) begin
      start      = 1'b1;
      elem_valid = 1'b1;
      elem_in    = 8'h55;
      @(posedge clk); #1;
      start      = 1'b0;
      elem_valid = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int v[9];
    bit s3;
    rst = 1'b1; start = 1'b0; size3 = 1'b0; elem_valid = 1'b0; elem_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", {24'b0, result}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_ready", {31'b0, elem_ready}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_m_a", {24'b0, m_a}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    v = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    load_matrix(1'b1, v, 0, 1'b0);

    v = '{2, 0, 0, 0, 3, 0, 0, 0, 4};
    load_matrix(1'b1, v, 1, 1'b0);

    v = '{3, 8, 4, 6, 0, 0, 0, 0, 0};
    load_matrix(1'b0, v, 0, 1'b0);
    check("x2_m_a", {24'b0, m_a}, 32'd1);
    check("x2_m_b", {24'b0, m_b}, 32'd0);
    check("x2_m_c", {24'b0, m_c}, 32'd0);
    check("x2_m_d", {24'b0, m_d}, 32'd0);
    check("x2_m_g", {24'b0, m_g}, 32'd0);
    check("x2_m_e", {24'b0, m_e}, 32'd3);
    check("x2_m_f", {24'b0, m_f}, 32'd8);
    check("x2_m_h", {24'b0, m_h}, 32'd4);
    check("x2_m_i", {24'b0, m_i}, 32'd6);
    check("x2_ref", {24'b0, ref_det(1'b0, v)}, 32'hF2);

    v = '{10, 0, 0, 0, 10, 0, 0, 0, 10};
    load_matrix(1'b1, v, 0, 1'b0);
    wait_idle();

    // Reset part way through a 3x3 load: nothing may complete.
    start = 1'b1; size3 = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      elem_valid = 1'b1;
      elem_in    = DATA_W'(k + 7);
      @(posedge clk); #1;
    end
    elem_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_ready", {31'b0, elem_ready}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_result", {24'b0, result}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("postrst_done", {31'b0, done}, 32'd0);

    v = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    load_matrix(1'b1, v, 0, 1'b0);

    // Spurious start/valid during LOAD gaps and SETTLE, then start in the done cycle.
    v = '{5, 250, 3, 7, 1, 9, 200, 4, 6};
    load_matrix(1'b1, v, 1, 1'b1);
    wait_done();
    v = '{7, 3, 2, 5, 0, 0, 0, 0, 0};
    load_matrix(1'b0, v, 0, 1'b1);

    for (int t = 0; t < 24; t++) begin
      s3 = 1'($urandom_range(0, 1));
      for (int k = 0; k < 9; k++) v[k] = $urandom_range(0, 255);
      if (t % 3 == 0) wait_done();
      load_matrix(s3, v, 2, 1'($urandom_range(0, 1)));
    end

    wait_idle();
    repeat (SC + 4) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
